c_cond_merge2: RTL and testbench

Clocked two-input conditional merge for the micropipeline control path. It is the join-side counterpart of the two-way conditional fork. Each of two upstream branches delivers a drive pulse plus payload. The block buffers one token per branch and arbitrates round-robin when both hold tokens. It forwards one token at a time to a single downstream stage and returns a per-branch free pulse once that branch's token has left its slot. It sits where forked branches rejoin before a shared downstream stage.

---
 rtl/c_cond_merge2_pkg.sv | 15 +
 rtl/c_cond_merge2_slot.sv | 43 ++++
 rtl/c_cond_merge2.sv | 108 ++++++++++
 tb/tb_c_cond_merge2.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/c_cond_merge2_pkg.sv
// Shared definitions for the two-input conditional merge: payload width
// default, source-select encodings and output FSM states.
package c_cond_merge2_pkg;

  localparam int DW_DEFAULT = 32;

  localparam logic SEL_B0 = 1'b0;
  localparam logic SEL_B1 = 1'b1;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/c_cond_merge2_slot.sv
// One-token buffer for a single merge branch. A drive pulse loads the slot
// when it is empty or being drained in the same cycle; a drive into a full,
// undrained slot is dropped and flagged as overflow.
module c_cond_merge2_slot
  import c_cond_merge2_pkg::*;
#(
  parameter int DW = DW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          drive,
  input  logic          grant,
  input  logic [DW-1:0] din,
  output logic          pend,
  output logic [DW-1:0] data,
  output logic          overflow
);

  logic load;

  // A grant frees the slot this edge, so a simultaneous drive is a refill.
  assign load     = drive & (~pend | grant);
  assign overflow = drive & pend & ~grant;

  // Occupancy flag: set by any accepted or refused drive, cleared by grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend <= 1'b0;
    end else if (drive) begin
      pend <= 1'b1;
    end else if (grant) begin
      pend <= 1'b0;
    end
  end

  // Payload register; only read while pend is set, so it needs no reset.
  always_ff @(posedge clk) begin
    if (load) begin
      data <= din;
    end
  end

endmodule

// File: rtl/c_cond_merge2.sv
// Two-input conditional merge: buffers one token per branch, arbitrates
// round-robin when both are pending, forwards one token at a time and
// returns a free pulse to the branch whose slot was emptied.
module c_cond_merge2
  import c_cond_merge2_pkg::*;
#(
  parameter int DW = DW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_drive0,
  input  logic [DW-1:0] i_data0,
  output logic          o_free0,
  input  logic          i_drive1,
  input  logic [DW-1:0] i_data1,
  output logic          o_free1,
  output logic          o_driveNext,
  output logic [DW-1:0] o_data,
  output logic          o_sel,
  input  logic          i_freeNext,
  output logic          o_err
);

  logic          pend0, pend1;
  logic [DW-1:0] data0, data1;
  logic          ovf0, ovf1;
  logic          grant0, grant1;
  logic          avail;
  logic          err_d;
  logic          rr_q;
  state_t        state_q, state_d;

  c_cond_merge2_slot #(.DW(DW)) u_slot0 (
    .clk      (clk),
    .rst_n    (rst_n),
    .drive    (i_drive0),
    .grant    (grant0),
    .din      (i_data0),
    .pend     (pend0),
    .data     (data0),
    .overflow (ovf0)
  );

  c_cond_merge2_slot #(.DW(DW)) u_slot1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .drive    (i_drive1),
    .grant    (grant1),
    .din      (i_data1),
    .pend     (pend1),
    .data     (data1),
    .overflow (ovf1)
  );

  // Arbitration, next-state and error accumulation.
  always_comb begin
    state_d = state_q;
    grant0  = 1'b0;
    grant1  = 1'b0;
    avail   = (state_q == IDLE) || ((state_q == BUSY) && i_freeNext);
    if (avail) begin
      if (pend0 && (!pend1 || (rr_q == SEL_B0))) begin
        grant0 = 1'b1;
      end else if (pend1) begin
        grant1 = 1'b1;
      end
    end
    if (grant0 || grant1) begin
      state_d = BUSY;
    end else if ((state_q == BUSY) && i_freeNext) begin
      state_d = IDLE;
    end
    err_d = o_err | ovf0 | ovf1 | ((state_q == IDLE) & i_freeNext);
  end

  // Output FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Forwarded token, pulse registers, round-robin pointer and sticky error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_driveNext <= 1'b0;
      o_free0     <= 1'b0;
      o_free1     <= 1'b0;
      o_data      <= '0;
      o_sel       <= SEL_B0;
      o_err       <= 1'b0;
      rr_q        <= SEL_B0;
    end else begin
      o_driveNext <= grant0 | grant1;
      o_free0     <= grant0;
      o_free1     <= grant1;
      o_err       <= err_d;
      if (grant0 || grant1) begin
        o_data <= grant1 ? data1 : data0;
        o_sel  <= grant1 ? SEL_B1 : SEL_B0;
        rr_q   <= grant1 ? SEL_B0 : SEL_B1;
      end
    end
  end

endmodule

// File: tb/tb_c_cond_merge2.sv
// Directed bench for c_cond_merge2: inputs change and outputs are sampled
// 1 ns after each rising edge.
module tb_c_cond_merge2;
  import c_cond_merge2_pkg::*;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_drive0, i_drive1, i_freeNext;
  logic [DW-1:0] i_data0, i_data1;
  logic          o_free0, o_free1, o_driveNext, o_sel, o_err;
  logic [DW-1:0] o_data;

  int passed = 0;
  int total  = 0;

  c_cond_merge2 #(.DW(DW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_drive0    (i_drive0),
    .i_data0     (i_data0),
    .o_free0     (o_free0),
    .i_drive1    (i_drive1),
    .i_data1     (i_data1),
    .o_free1     (o_free1),
    .o_driveNext (o_driveNext),
    .o_data      (o_data),
    .o_sel       (o_sel),
    .i_freeNext  (i_freeNext),
    .o_err       (o_err)
  );

  always #5 clk = ~clk;

  // Advance to 1 ns past the next rising edge and drop all input pulses.
  task automatic tick();
    @(posedge clk);
    #1;
    i_drive0   = 1'b0;
    i_drive1   = 1'b0;
    i_freeNext = 1'b0;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n      = 1'b0;
    i_drive0   = 1'b0;
    i_drive1   = 1'b0;
    i_freeNext = 1'b0;
    i_data0    = '0;
    i_data1    = '0;

    // Reset state
    tick();
    check("rst_drv",  o_driveNext, 0);
    check("rst_free0", o_free0, 0);
    check("rst_free1", o_free1, 0);
    check("rst_data", o_data, 0);
    check("rst_sel",  o_sel, 0);
    check("rst_err",  o_err, 0);
    tick();
    rst_n = 1'b1;

    // Single token: drive at t, pulses at t+2, ack at t+4
    i_drive0 = 1'b1; i_data0 = 32'hA5A5_0001;
    tick();
    check("s_drv_t1", o_driveNext, 0);
    tick();
    check("s_drv_t2",  o_driveNext, 1);
    check("s_free0",   o_free0, 1);
    check("s_free1",   o_free1, 0);
    check("s_sel",     o_sel, 0);
    check("s_data",    o_data, 32'hA5A5_0001);
    tick();
    check("s_drv_t3",  o_driveNext, 0);
    check("s_free0_t3", o_free0, 0);
    check("s_hold",    o_data, 32'hA5A5_0001);
    tick();
    i_freeNext = 1'b1;
    tick();
    check("s_idle",    dut.state_q, IDLE);
    check("s_drv_t5",  o_driveNext, 0);
    check("s_err",     o_err, 0);

    // Simultaneous arrival just after reset: branch 0 first
    do_reset();
    i_drive0 = 1'b1; i_data0 = 32'h10;
    i_drive1 = 1'b1; i_data1 = 32'h20;
    tick();
    tick();
    check("sim_drv0",  o_driveNext, 1);
    check("sim_sel0",  o_sel, 0);
    check("sim_data0", o_data, 32'h10);
    check("sim_free0", o_free0, 1);
    tick();
    i_freeNext = 1'b1;
    tick();
    check("sim_drv1",   o_driveNext, 1);
    check("sim_sel1",   o_sel, 1);
    check("sim_data1",  o_data, 32'h20);
    check("sim_free1",  o_free1, 1);
    check("sim_nfree0", o_free0, 0);

    // Overflow: BUSY held, branch 1 driven twice
    do_reset();
    i_drive0 = 1'b1; i_data0 = 32'h7;
    tick();
    tick();
    check("ov_busy", o_driveNext, 1);
    i_drive1 = 1'b1; i_data1 = 32'h1;
    tick();
    check("ov_err_pre", o_err, 0);
    i_drive1 = 1'b1; i_data1 = 32'h2;
    tick();
    check("ov_err", o_err, 1);
    i_freeNext = 1'b1;
    tick();
    check("ov_drv",  o_driveNext, 1);
    check("ov_sel",  o_sel, 1);
    check("ov_data", o_data, 32'h1);
    check("ov_sticky", o_err, 1);

    // Refill: new token in the same cycle slot 0 is granted
    do_reset();
    i_drive0 = 1'b1; i_data0 = 32'h2;
    tick();
    i_drive0 = 1'b1; i_data0 = 32'h3;
    tick();
    check("rf_drv0",  o_driveNext, 1);
    check("rf_data0", o_data, 32'h2);
    check("rf_err0",  o_err, 0);
    tick();
    i_freeNext = 1'b1;
    tick();
    check("rf_drv1",  o_driveNext, 1);
    check("rf_data1", o_data, 32'h3);
    check("rf_sel1",  o_sel, 0);
    check("rf_err1",  o_err, 0);

    // Fairness: freed branch re-driven on each free pulse, 8 grants
    do_reset();
    i_drive0 = 1'b1; i_data0 = 32'h100;
    i_drive1 = 1'b1; i_data1 = 32'h200;
    tick();
    tick();
    for (int i = 0; i < 8; i++) begin
      check($sformatf("fair_drv%0d", i), o_driveNext, 1);
      check($sformatf("fair_sel%0d", i), o_sel, i % 2);
      check($sformatf("fair_free%0d", i), {o_free1, o_free0}, (i % 2) ? 2'b10 : 2'b01);
      if (i % 2) begin
        i_drive1 = 1'b1; i_data1 = 32'h200 + i;
      end else begin
        i_drive0 = 1'b1; i_data0 = 32'h100 + i;
      end
      tick();
      i_freeNext = 1'b1;
      tick();
    end
    check("fair_sel8", o_sel, 0);
    check("fair_err",  o_err, 0);
    // Refill branch 0 so both slots are pending while BUSY
    i_drive0 = 1'b1; i_data0 = 32'h1FF;
    tick();

    // Reset mid-operation
    rst_n = 1'b0;
    #1;
    check("mr_drv",   o_driveNext, 0);
    check("mr_free",  {o_free1, o_free0}, 0);
    check("mr_data",  o_data, 0);
    check("mr_sel",   o_sel, 0);
    check("mr_err",   o_err, 0);
    tick();
    rst_n = 1'b1;
    tick();
    check("mr_nodrv1", o_driveNext, 0);
    tick();
    check("mr_nodrv2", o_driveNext, 0);
    i_freeNext = 1'b1;
    tick();
    check("mr_stray_drv",  o_driveNext, 0);
    check("mr_stray_free", {o_free1, o_free0}, 0);
    check("mr_stray_err",  o_err, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
